// File: rtl/fifo1_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Fifo1 arbiter.
// Arbiter state encoding and tag-width helper.
// No logic here; imported by the interface users and sub-modules.
package fifo1_rr_arbiter_pkg;

    // IDLE arbitrates among all requesters; LOCKED serves only the burst owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index for n requesters (at least one bit).
    function automatic int tag_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo1_rr_arbiter_if.sv
// Bundle of the per-requester enq methods and the Fifo1-style out methods.
// Pure wiring, no latency.
// Requesters present enq_ena/enq_v/enq_last and hold them until enq_rdy.
interface fifo1_rr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
);
    // enq side: one slice per requester
    logic [NREQ-1:0]        enq_ena;
    logic [NREQ*DATA_W-1:0] enq_v;
    logic [NREQ-1:0]        enq_last;
    logic [NREQ-1:0]        enq_rdy;

    // out side: single-entry slot
    logic [DATA_W-1:0]      first;
    logic [TAG_W-1:0]       tag;
    logic                   first_rdy;
    logic                   deq_ena;
    logic                   deq_rdy;

    // Environment side: drives requests and dequeues, observes the slot.
    modport master (
        output enq_ena, enq_v, enq_last, deq_ena,
        input  enq_rdy, first, tag, first_rdy, deq_rdy
    );

    // Arbiter side.
    modport slave (
        input  enq_ena, enq_v, enq_last, deq_ena,
        output enq_rdy, first, tag, first_rdy, deq_rdy
    );

endinterface

// File: rtl/fifo1_rr_arbiter_pick.sv
// Rotating priority picker: first set request strictly after ptr, modulo NREQ.
// Purely combinational, zero latency.
// No handshake; valid=0 when no request is set.
module rr_priority_pick
    import fifo1_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = tag_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    output logic             valid,
    output logic [TAG_W-1:0] idx
);

    // Scan from the farthest candidate (ptr itself) down to the nearest
    // (ptr+1) so the nearest set request is the one left in idx.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            logic [TAG_W-1:0] cand;
            cand = TAG_W'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo1_rr_arbiter.sv
// Round-robin arbiter feeding one single-entry slot with burst locking.
// Latency: accepted beat visible on first/tag one cycle after enq_ena&enq_rdy.
// Backpressure: enq_rdy only when slot empty or being dequeued; at most one bit set.
module fifo1_rr_arbiter
    import fifo1_rr_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = tag_w(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    fifo1_rr_arbiter_if.slave   bus
);

    // arbitration state
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [TAG_W-1:0]  owner;
    logic [TAG_W-1:0]  owner_nxt;
    logic [TAG_W-1:0]  ptr;

    // slot
    logic              full;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;

    // datapath / decode
    logic              deq;
    logic              space;
    logic              pick_vld;
    logic [TAG_W-1:0]  pick_idx;
    logic              grant_vld;
    logic [TAG_W-1:0]  grant_idx;
    logic [NREQ-1:0]   rdy;
    logic              accept;
    logic [DATA_W-1:0] beats [NREQ];
    logic [DATA_W-1:0] beat_v;
    logic              beat_last;

    // A dequeue frees the slot in the same cycle, so a new beat can land
    // behind it and sustain one beat per cycle.
    assign deq   = bus.deq_ena & full;
    assign space = ~full | deq;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_pick (
        .req   (bus.enq_ena),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Grant selection: a locked owner keeps the grant even when it idles,
    // otherwise the rotating picker decides.
    always_comb begin
        grant_vld = pick_vld;
        grant_idx = pick_idx;
        if (state == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = owner;
        end
    end

    // One-hot ready decode, forced low during reset.
    always_comb begin
        rdy = '0;
        if (!rst && grant_vld && space) begin
            rdy[grant_idx] = 1'b1;
        end
    end

    assign accept = |(rdy & bus.enq_ena);

    // Split the flat beat bus into per-requester words for the mux.
    for (genvar g = 0; g < NREQ; g++) begin : g_beats
        assign beats[g] = bus.enq_v[g*DATA_W +: DATA_W];
    end

    assign beat_v    = beats[grant_idx];
    assign beat_last = bus.enq_last[grant_idx];

    // Next-state: a non-final beat locks onto its sender, a final beat unlocks.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (accept) begin
            if (beat_last) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = LOCKED;
                owner_nxt = grant_idx;
            end
        end
    end

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Priority pointer moves only on accept, making the last winner lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= TAG_W'(NREQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

    // Slot: enqueue wins over dequeue, so deq+enq keeps full and replaces the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
            tag  <= '0;
        end else if (accept) begin
            full <= 1'b1;
            data <= beat_v;
            tag  <= grant_idx;
        end else if (deq) begin
            full <= 1'b0;
        end
    end

    assign bus.enq_rdy   = rdy;
    assign bus.first     = data;
    assign bus.tag       = tag;
    assign bus.first_rdy = full;
    assign bus.deq_rdy   = full;

endmodule

// File: tb/tb_fifo1_rr_arbiter.sv
// Self-checking bench for fifo1_rr_arbiter against a slot/pointer reference model.
// Directed scenarios followed by randomized traffic with a per-tag scoreboard.
// Requesters hold their beat until accepted; dequeue is randomized.
module tb_fifo1_rr_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] v_arr [NREQ];

    fifo1_rr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    fifo1_rr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) bus.enq_v[i*DATA_W +: DATA_W] = v_arr[i];
    end

    // ---------------- reference model ----------------
    bit                m_full;
    logic [DATA_W-1:0] m_data;
    int                m_tag;
    int                m_ptr;
    bit                m_locked;
    int                m_owner;

    function automatic logic [NREQ-1:0] model_rdy();
        logic [NREQ-1:0] r;
        r = '0;
        if (rst) return r;
        if (m_full && !bus.deq_ena) return r;
        if (m_locked) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (bus.enq_ena[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        logic [NREQ-1:0] r;
        int w;
        r = model_rdy();
        w = -1;
        if (rst) begin
            m_full = 0; m_data = '0; m_tag = 0; m_ptr = NREQ - 1;
            m_locked = 0; m_owner = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (r[i] && bus.enq_ena[i]) w = i;
            if (w >= 0) begin
                m_full = 1; m_data = v_arr[w]; m_tag = w; m_ptr = w;
                m_locked = !bus.enq_last[w];
                m_owner = w;
            end else if (bus.deq_ena && m_full) begin
                m_full = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enq_ena = '0;
        bus.enq_last = '1;
        bus.deq_ena = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.enq_ena = '1;
        bus.enq_last = '1;
        bus.deq_ena = 1'b0;
        for (int i = 0; i < NREQ; i++) v_arr[i] = 32'h5000 + i;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_rdy_async: got %b want 0000", bus.enq_rdy); end
        tick();
        tick();
        n_cmp++; if (bus.enq_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_rdy: got %b want 0000", bus.enq_rdy); end
        n_cmp++; if (bus.first_rdy !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.first_rdy); end
        n_cmp++; if (bus.first !== 32'h0 || bus.tag !== 2'd0) begin n_err++; $display("FAIL reset_slot: got %h/%0d want 0/0", bus.first, bus.tag); end
        rst = 1'b0;
        bus.enq_ena = 4'b0001;
        v_arr[0] = 32'hA5;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b0001) begin n_err++; $display("FAIL first_rdy_vec: got %b want 0001", bus.enq_rdy); end
        tick();
        n_cmp++; if (bus.first_rdy !== 1'b1 || bus.first !== 32'hA5 || bus.tag !== 2'd0)
            begin n_err++; $display("FAIL first_beat: got full=%b %h tag=%0d want 1 a5 0", bus.first_rdy, bus.first, bus.tag); end
        bus.enq_ena = '0;
        bus.deq_ena = 1'b1;
        #1;
        n_cmp++; if (bus.deq_rdy !== 1'b1) begin n_err++; $display("FAIL deq_rdy: got %b want 1", bus.deq_rdy); end
        tick();
        n_cmp++; if (bus.first_rdy !== 1'b0) begin n_err++; $display("FAIL deq_empties: got %b want 0", bus.first_rdy); end
        bus.deq_ena = 1'b0;
    endtask

    task automatic test_fairness();
        do_reset();
        bus.enq_ena = '1;
        bus.enq_last = '1;
        bus.deq_ena = 1'b1;
        for (int i = 0; i < NREQ; i++) v_arr[i] = 32'h100 + i;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_cmp++; if (bus.enq_rdy !== model_rdy()) begin n_err++; $display("FAIL fair_rdy c%0d: got %b want %b", c, bus.enq_rdy, model_rdy()); end
            tick();
            n_cmp++;
            if (bus.first_rdy !== 1'b1 || int'(bus.tag) != c % NREQ || bus.first !== 32'h100 + 32'(c % NREQ))
                begin n_err++; $display("FAIL fair_tag c%0d: got tag=%0d %h want tag=%0d", c, bus.tag, bus.first, c % NREQ); end
        end
        bus.enq_ena = '0;
        tick();
        bus.deq_ena = 1'b0;
    endtask

    task automatic test_burst();
        bit          e1 [5] = '{1, 1, 0, 1, 0};
        bit          l1 [5] = '{0, 0, 1, 1, 1};
        logic [3:0]  er [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        bit          ef [5] = '{1, 1, 0, 1, 1};
        int          et [5] = '{1, 1, 1, 1, 2};
        logic [31:0] ed [5] = '{32'h110, 32'h111, 32'h111, 32'h112, 32'h200};
        do_reset();
        bus.deq_ena = 1'b1;
        v_arr[2] = 32'h200;
        for (int c = 0; c < 5; c++) begin
            bus.enq_ena = {1'b0, 1'b1, e1[c], 1'b0};
            bus.enq_last = {2'b11, l1[c], 1'b1};
            v_arr[1] = (c < 2) ? 32'h110 + 32'(c) : 32'h112;
            #1;
            n_cmp++; if (bus.enq_rdy !== er[c]) begin n_err++; $display("FAIL burst_rdy c%0d: got %b want %b", c, bus.enq_rdy, er[c]); end
            tick();
            n_cmp++; if (bus.first_rdy !== ef[c]) begin n_err++; $display("FAIL burst_full c%0d: got %b want %b", c, bus.first_rdy, ef[c]); end
            if (ef[c]) begin
                n_cmp++;
                if (int'(bus.tag) != et[c] || bus.first !== ed[c])
                    begin n_err++; $display("FAIL burst_beat c%0d: got tag=%0d %h want tag=%0d %h", c, bus.tag, bus.first, et[c], ed[c]); end
            end
        end
        bus.enq_ena = '0;
        tick();
        bus.deq_ena = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.enq_ena = 4'b0001;
        bus.enq_last = '1;
        v_arr[0] = 32'h11;
        v_arr[1] = 32'h22;
        tick();
        bus.enq_ena = '1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (bus.enq_rdy !== 4'b0000) begin n_err++; $display("FAIL bp_rdy c%0d: got %b want 0000", c, bus.enq_rdy); end
            tick();
            n_cmp++; if (bus.first !== 32'h11 || bus.first_rdy !== 1'b1) begin n_err++; $display("FAIL bp_hold c%0d: got %h want 11", c, bus.first); end
        end
        bus.deq_ena = 1'b1;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b0010) begin n_err++; $display("FAIL bp_deq_rdy: got %b want 0010", bus.enq_rdy); end
        bus.enq_ena = 4'b0010;
        tick();
        n_cmp++; if (bus.first_rdy !== 1'b1 || bus.first !== 32'h22 || bus.tag !== 2'd1)
            begin n_err++; $display("FAIL bp_replace: got full=%b %h tag=%0d want 1 22 1", bus.first_rdy, bus.first, bus.tag); end
        bus.enq_ena = '0;
        tick();
        bus.deq_ena = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.enq_ena = 4'b1000;
        bus.enq_last = 4'b0000;
        v_arr[3] = 32'h33;
        v_arr[0] = 32'h44;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b1000) begin n_err++; $display("FAIL rm_grab: got %b want 1000", bus.enq_rdy); end
        tick();
        bus.enq_ena = '1;
        bus.enq_last = '1;
        bus.deq_ena = 1'b1;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b1000) begin n_err++; $display("FAIL rm_locked: got %b want 1000", bus.enq_rdy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b0000) begin n_err++; $display("FAIL rm_rst_rdy: got %b want 0000", bus.enq_rdy); end
        tick();
        n_cmp++; if (bus.first_rdy !== 1'b0) begin n_err++; $display("FAIL rm_rst_full: got %b want 0", bus.first_rdy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.enq_rdy !== 4'b0001) begin n_err++; $display("FAIL rm_release: got %b want 0001", bus.enq_rdy); end
        tick();
        n_cmp++; if (bus.tag !== 2'd0 || bus.first !== 32'h44) begin n_err++; $display("FAIL rm_winner: got tag=%0d %h want 0 44", bus.tag, bus.first); end
        bus.enq_ena = '0;
        tick();
        bus.deq_ena = 1'b0;
    endtask

    task automatic test_random();
        int rem [NREQ];
        int seq [NREQ];
        int nxt_deq [NREQ];
        int wait_wins [NREQ];
        bit started [NREQ];
        int acc_cnt;
        int deq_cnt;
        logic [NREQ-1:0] r;
        int w;
        int tg;
        logic [31:0] exp_d;
        do_reset();
        acc_cnt = 0;
        deq_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; seq[i] = 0; nxt_deq[i] = 0; wait_wins[i] = 0; started[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && cyc < 2900 && $urandom_range(0, 9) < 3) begin
                    rem[i] = $urandom_range(1, 3);
                    started[i] = 0;
                end
                if (rem[i] == 0) bus.enq_ena[i] = 1'b0;
                else if (started[i] && $urandom_range(0, 9) < 2) bus.enq_ena[i] = 1'b0;
                else bus.enq_ena[i] = 1'b1;
                bus.enq_last[i] = (rem[i] <= 1);
                v_arr[i] = (32'(i) << 24) | (32'(seq[i]) & 32'h00FF_FFFF);
            end
            bus.deq_ena = (cyc >= 2900) ? 1'b1 : ($urandom_range(0, 9) < 6);
            #1;
            r = model_rdy();
            n_cmp++; if (bus.enq_rdy !== r) begin n_err++; $display("FAIL rnd_rdy cyc%0d: got %b want %b", cyc, bus.enq_rdy, r); end
            n_cmp++; if (!$onehot0(bus.enq_rdy)) begin n_err++; $display("FAIL rnd_onehot0 cyc%0d: got %b want onehot0", cyc, bus.enq_rdy); end
            n_cmp++; if (bus.first_rdy !== m_full) begin n_err++; $display("FAIL rnd_full cyc%0d: got %b want %b", cyc, bus.first_rdy, m_full); end
            if (m_full) begin
                n_cmp++;
                if (bus.first !== m_data || int'(bus.tag) != m_tag)
                    begin n_err++; $display("FAIL rnd_slot cyc%0d: got %h/%0d want %h/%0d", cyc, bus.first, bus.tag, m_data, m_tag); end
                if (bus.deq_ena) begin
                    tg = int'(bus.tag);
                    exp_d = (32'(tg) << 24) | (32'(nxt_deq[tg]) & 32'h00FF_FFFF);
                    n_cmp++;
                    if (bus.first !== exp_d) begin n_err++; $display("FAIL rnd_order cyc%0d: got %h want %h", cyc, bus.first, exp_d); end
                    nxt_deq[tg]++;
                    deq_cnt++;
                end
            end
            w = -1;
            for (int i = 0; i < NREQ; i++) if (r[i] && bus.enq_ena[i]) w = i;
            if (w >= 0) begin
                if (!m_locked) begin
                    for (int j = 0; j < NREQ; j++) begin
                        if (j != w && bus.enq_ena[j] && !started[j]) begin
                            wait_wins[j]++;
                            n_cmp++;
                            if (wait_wins[j] > NREQ - 1)
                                begin n_err++; $display("FAIL rnd_starve req%0d: got %0d wins while waiting want <=%0d", j, wait_wins[j], NREQ - 1); end
                        end
                    end
                    wait_wins[w] = 0;
                end
                seq[w]++;
                rem[w]--;
                started[w] = (rem[w] != 0);
                acc_cnt++;
            end
            tick();
        end
        bus.enq_ena = '0;
        bus.deq_ena = 1'b1;
        #1;
        if (m_full) begin
            tg = int'(bus.tag);
            exp_d = (32'(tg) << 24) | (32'(nxt_deq[tg]) & 32'h00FF_FFFF);
            n_cmp++;
            if (bus.first !== exp_d) begin n_err++; $display("FAIL rnd_drain: got %h want %h", bus.first, exp_d); end
            nxt_deq[tg]++;
            deq_cnt++;
        end
        tick();
        bus.deq_ena = 1'b0;
        n_cmp++; if (deq_cnt != acc_cnt) begin n_err++; $display("FAIL rnd_count: got %0d dequeued want %0d", deq_cnt, acc_cnt); end
        for (int i = 0; i < NREQ; i++) begin
            n_cmp++;
            if (nxt_deq[i] != seq[i]) begin n_err++; $display("FAIL rnd_req%0d_total: got %0d want %0d", i, nxt_deq[i], seq[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.enq_ena = '0;
        bus.enq_last = '1;
        bus.deq_ena = 1'b0;
        for (int i = 0; i < NREQ; i++) v_arr[i] = '0;
        m_full = 0; m_data = '0; m_tag = 0; m_ptr = NREQ - 1; m_locked = 0; m_owner = 0;
        test_reset();
        test_fairness();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
